parity_rx_jdl25175: RTL

Serial frame receiver with parity check. It is the receive end of the 9-bit parity link, whose transmitter uses the hc280 generator to append a parity bit. It deserializes start + 8 data bits (LSB first) + parity + stop, recomputes parity over the 9 received bits, and presents the byte through a valid/ack handshake with error flags and a saturating error counter. It sits between the line synchronizer and the byte consumer.

---
 rtl/parity_rx_jdl25175_pkg.sv | 13 +
 rtl/parity_chk_jdl25175.sv | 13 +
 rtl/parity_rx_jdl25175.sv | 104 ++++++++++
 3 files changed

// File: rtl/parity_rx_jdl25175_pkg.sv
// Shared definitions for the 9-bit parity link receiver.
// Also used by the link's other blocks.
package parity_rx_jdl25175_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic IDLE_LEVEL      = 1'b1;
endpackage

// File: rtl/parity_chk_jdl25175.sv
// Combinational 9-bit parity checker.
// err_o=1 when data+parity violate the selected even/odd parity rule.
module parity_chk_jdl25175
  import parity_rx_jdl25175_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [FRAME_DATA_BITS-1:0] data_i,
  input  logic                       par_i,
  output logic                       err_o
);
  assign err_o = (^data_i) ^ par_i ^ ODD_PARITY;
endmodule

// File: rtl/parity_rx_jdl25175.sv
// Serial frame receiver: start + 8 data (LSB first) + parity + stop.
// Delivers bytes over a valid/ack handshake with parity status and a saturating error count.
module parity_rx_jdl25175
  import parity_rx_jdl25175_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic                       serial_in,
  input  logic                       data_ack,
  input  logic                       err_clr,
  output logic [FRAME_DATA_BITS-1:0] data_out,
  output logic                       data_valid,
  output logic                       parity_err,
  output logic                       framing_err,
  output logic                       overrun,
  output logic [ERR_CNT_W-1:0]       err_count
);
  rx_state_e                  state_q;
  logic [2:0]                 bit_cnt_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic                       par_q;
  logic [FRAME_DATA_BITS-1:0] data_q;
  logic                       valid_q, perr_q, ferr_q, ovr_q;
  logic [ERR_CNT_W-1:0]       cnt_q, cnt_d;

  logic perr_w, stop_smp, good_frame, bad_frame, load, err_evt;

  parity_chk_jdl25175 #(.ODD_PARITY(ODD_PARITY)) u_chk (
    .data_i(shift_q),
    .par_i (par_q),
    .err_o (perr_w)
  );

  assign stop_smp   = sample_en && (state_q == ST_STOP);
  assign good_frame = stop_smp && (serial_in == IDLE_LEVEL);
  assign bad_frame  = stop_smp && (serial_in != IDLE_LEVEL);
  assign load       = good_frame && (!valid_q || data_ack);
  // Parity errors count even when the frame is dropped for overrun.
  assign err_evt    = bad_frame || (good_frame && perr_w);

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)                    cnt_d = '0;
    else if (err_evt && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= cnt_d;
      if (data_ack) valid_q <= 1'b0;
      if (sample_en) begin
        unique case (state_q)
          ST_IDLE: if (serial_in != IDLE_LEVEL) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
          ST_DATA: begin
            shift_q   <= {serial_in, shift_q[FRAME_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= serial_in;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (bad_frame) ferr_q <= 1'b1;
            else if (load) begin
              data_q  <= shift_q;
              perr_q  <= perr_w;
              valid_q <= 1'b1;
            end else ovr_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign err_count   = cnt_q;
endmodule
